// File: rtl/pga_spi_responder.sv
// SPI gain-register responder: oversamples sck/cs_n/mosi on clk, commits an
// exact WIDTH-bit frame on cs_n rise and reads back the previous code on miso.
module pga_spi_responder #(
  parameter int WIDTH                  = 8,
  parameter int SYNC_STAGES            = 2,
  parameter logic [WIDTH-1:0] RESET_CODE = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sck,
  input  logic             cs_n,
  input  logic             mosi,
  output logic             miso,
  output logic [WIDTH-1:0] gain_o,
  output logic             gain_valid_o,
  output logic             frame_err_o
);

  localparam logic [1:0] WAIT_IDLE = 2'd0;
  localparam logic [1:0] IDLE      = 2'd1;
  localparam logic [1:0] RECV      = 2'd2;
  localparam logic [1:0] COMMIT    = 2'd3;

  localparam int CMAX = ((WIDTH > SYNC_STAGES) ? WIDTH : SYNC_STAGES) + 1;
  localparam int CW   = $clog2(CMAX + 1);

  logic [SYNC_STAGES-1:0] sck_sync, cs_sync, mosi_sync;
  logic                   sck_d, cs_d;
  logic                   sck_s, cs_s, mosi_s;
  logic                   sck_rise, sck_fall, cs_fall, cs_rise;
  logic [1:0]             state;
  logic [CW-1:0]          cnt;
  logic [WIDTH-1:0]       rx_sr, tx_sr;

  assign sck_s  = sck_sync[SYNC_STAGES-1];
  assign cs_s   = cs_sync[SYNC_STAGES-1];
  assign mosi_s = mosi_sync[SYNC_STAGES-1];

  assign sck_rise = sck_s & ~sck_d;
  assign sck_fall = ~sck_s & sck_d;
  assign cs_fall  = ~cs_s & cs_d;
  assign cs_rise  = cs_s & ~cs_d;

  assign miso = (state == RECV) ? tx_sr[WIDTH-1] : 1'b0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sck_sync  <= '0;
      cs_sync   <= '1;
      mosi_sync <= '0;
      sck_d     <= 1'b0;
      cs_d      <= 1'b1;
    end else begin
      sck_sync  <= {sck_sync[SYNC_STAGES-2:0], sck};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_n};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
      sck_d     <= sck_s;
      cs_d      <= cs_s;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= WAIT_IDLE;
      cnt          <= '0;
      rx_sr        <= '0;
      tx_sr        <= '0;
      gain_o       <= RESET_CODE;
      gain_valid_o <= 1'b0;
      frame_err_o  <= 1'b0;
    end else begin
      gain_valid_o <= 1'b0;
      frame_err_o  <= 1'b0;
      case (state)
        // The sync chain resets to cs_n=1, so let it fill with the real pin
        // level before trusting cs_s; otherwise a mid-frame reset release
        // would look like a fresh cs_fall.
        WAIT_IDLE: begin
          if (cnt != CW'(SYNC_STAGES + 1)) cnt <= cnt + 1'b1;
          else if (cs_s) state <= IDLE;
        end
        IDLE: begin
          if (cs_fall) begin
            state <= RECV;
            cnt   <= '0;
            rx_sr <= '0;
            tx_sr <= gain_o;
          end
        end
        RECV: begin
          if (cs_rise) begin
            state <= COMMIT;
            if (cnt == CW'(WIDTH)) begin
              gain_o       <= rx_sr;
              gain_valid_o <= 1'b1;
            end else begin
              frame_err_o  <= 1'b1;
            end
          end else begin
            if (sck_rise) begin
              rx_sr <= {rx_sr[WIDTH-2:0], mosi_s};
              if (cnt != CW'(WIDTH + 1)) cnt <= cnt + 1'b1;
            end
            if (sck_fall) tx_sr <= {tx_sr[WIDTH-2:0], 1'b0};
          end
        end
        COMMIT:  state <= IDLE;
        default: state <= WAIT_IDLE;
      endcase
    end
  end

endmodule
